// File: rtl/adc045_slave_model.sv
// adc045_slave_model: ADC-side responder for the four-wire SPI converter link.
// Decodes controller commands, holds four configuration registers, runs the
// conversion timer and shifts 24-bit results out in SPI mode 1.
module adc045_slave_model #(
  parameter int CONV_CYCLES = 50000,
  parameter int DATA_W      = 24
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              CS,
  input  logic              SCLK,
  input  logic              DIN,
  input  logic              nRST,
  input  logic              START,
  output logic              DRDY,
  output logic              DOUT,
  input  logic [DATA_W-1:0] sample_i,
  output logic [3:0]        mux_o,
  output logic [31:0]       cfg_o
);

  localparam int TMR_W = $clog2(CONV_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CONV_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CMD, RDOUT, WDATA, RDREG} state_t;

  state_t state, state_next;

  logic [1:0] cs_sync, sclk_sync, din_sync, nrst_sync, start_sync;
  logic       cs_d, sclk_d, start_d;
  logic       cs_s, din_s, nrst_s;
  logic       cs_fall, sclk_rise, sclk_fall, start_rise;

  logic [7:0]        regs [4];
  logic [4:0]        bit_cnt;
  logic [1:0]        byte_cnt;
  logic [1:0]        addr;
  logic [7:0]        shift_in;
  logic [7:0]        rx_byte;
  logic [DATA_W-1:0] shift_out;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] pend_val;
  logic [DATA_W-1:0] commit_val;
  logic              dout;
  logic              drdy;
  logic              blip;
  logic              pending;
  logic              conv_active;
  logic [TMR_W-1:0]  timer;

  logic       byte_done, last_bit;
  logic       cmd_reset, cmd_start, cmd_pdown, cmd_wreg, cmd_rreg;
  logic       load_reg, load_result;
  logic [1:0] load_addr;
  logic       clear, cm, trigger, conv_done;
  logic       leave_rdout, new_res, hold_new, commit;

  assign cs_s       = cs_sync[1];
  assign din_s      = din_sync[1];
  assign nrst_s     = nrst_sync[1];
  assign cs_fall    = !cs_s && cs_d;
  assign sclk_rise  = sclk_sync[1] && !sclk_d;
  assign sclk_fall  = !sclk_sync[1] && sclk_d;
  assign start_rise = start_sync[1] && !start_d;

  assign rx_byte   = {shift_in[6:0], din_s};
  assign last_bit  = (state == RDOUT) ? (bit_cnt == 5'(DATA_W - 1)) : (bit_cnt == 5'd7);
  assign byte_done = sclk_fall && !cs_s && (bit_cnt == 5'd7) &&
                     (state == CMD || state == WDATA || state == RDREG);

  // Pin reset and the RESET command clear the same state; only the FSM target differs.
  assign clear       = !nrst_s || cmd_reset;
  assign cm          = regs[1][2];
  assign trigger     = start_rise || cmd_start;
  assign conv_done   = conv_active && (timer == '0);
  assign load_result = (state_next == RDOUT) && (state != RDOUT);

  // A result arriving mid-read is parked until the read is over; reset or
  // powerdown decoded on the completion cycle drops it.
  assign leave_rdout = (state == RDOUT) && (state_next != RDOUT);
  assign new_res     = conv_done && !cmd_pdown && !cmd_reset;
  assign hold_new    = new_res && (state == RDOUT) && !leave_rdout;
  assign commit      = (new_res && !hold_new) || (leave_rdout && pending);
  assign commit_val  = new_res ? sample_i : pend_val;

  assign DRDY  = drdy;
  assign DOUT  = dout;
  assign mux_o = regs[0][7:4];
  assign cfg_o = {regs[3], regs[2], regs[1], regs[0]};

  // Two-flop synchronizers plus edge-detect registers for the control pins.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      cs_sync    <= 2'b11;
      sclk_sync  <= 2'b00;
      nrst_sync  <= 2'b11;
      start_sync <= 2'b00;
      cs_d       <= 1'b1;
      sclk_d     <= 1'b0;
      start_d    <= 1'b0;
    end else begin
      cs_sync    <= {cs_sync[0], CS};
      sclk_sync  <= {sclk_sync[0], SCLK};
      nrst_sync  <= {nrst_sync[0], nRST};
      start_sync <= {start_sync[0], START};
      cs_d       <= cs_sync[1];
      sclk_d     <= sclk_sync[1];
      start_d    <= start_sync[1];
    end
  end

  // Serial data input synchronizer.
  always_ff @(posedge clk) begin
    din_sync <= {din_sync[0], DIN};
  end

  // SPI FSM state register; the pin reset parks it in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_l || !nrst_s) state <= IDLE;
    else                   state <= state_next;
  end

  // Next-state logic and command decode.
  always_comb begin
    state_next = state;
    cmd_reset  = 1'b0;
    cmd_start  = 1'b0;
    cmd_pdown  = 1'b0;
    cmd_wreg   = 1'b0;
    cmd_rreg   = 1'b0;
    load_reg   = 1'b0;
    load_addr  = addr + 2'd1;
    if (cs_s) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (cs_fall) state_next = drdy ? CMD : RDOUT;
        CMD: if (byte_done) begin
          casez (rx_byte)
            8'h06: cmd_reset = 1'b1;
            8'h08: cmd_start = 1'b1;
            8'h02: cmd_pdown = 1'b1;
            8'h10: state_next = RDOUT;
            8'b0100_????: begin
              cmd_wreg   = 1'b1;
              state_next = WDATA;
            end
            8'b0010_????: begin
              cmd_rreg   = 1'b1;
              state_next = RDREG;
              load_reg   = 1'b1;
              load_addr  = rx_byte[3:2];
            end
            default: ;
          endcase
        end
        RDOUT: if (sclk_fall && last_bit) state_next = CMD;
        WDATA: if (byte_done && byte_cnt == 2'd0) state_next = CMD;
        RDREG: if (byte_done) begin
          if (byte_cnt == 2'd0) state_next = CMD;
          else                  load_reg = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Bit/byte counters, register file writes and the DOUT pin register.
  always_ff @(posedge clk) begin
    if (!rst_l || clear) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      addr     <= '0;
      dout     <= 1'b0;
    end else begin
      if (cs_s || state == IDLE) bit_cnt <= '0;
      else if (sclk_fall)        bit_cnt <= last_bit ? '0 : bit_cnt + 5'd1;

      if (cmd_wreg || cmd_rreg) begin
        addr     <= rx_byte[3:2];
        byte_cnt <= rx_byte[1:0];
      end else if (byte_done && (state == WDATA || state == RDREG)) begin
        addr     <= addr + 2'd1;
        byte_cnt <= byte_cnt - 2'd1;
      end

      if (byte_done && state == WDATA) regs[addr] <= rx_byte;

      if (!(state_next == RDOUT || state_next == RDREG)) dout <= 1'b0;
      else if (load_result)                              dout <= result[DATA_W-1];
      else if (load_reg)                                 dout <= regs[load_addr][7];
      else if (sclk_rise)                                dout <= shift_out[DATA_W-1];
    end
  end

  // Conversion timer, DRDY handshake and the pending-result flag.
  always_ff @(posedge clk) begin
    if (!rst_l || clear) begin
      conv_active <= 1'b0;
      timer       <= '0;
      drdy        <= 1'b1;
      blip        <= 1'b0;
      pending     <= 1'b0;
    end else begin
      if (cmd_pdown) begin
        conv_active <= 1'b0;
      end else if (trigger) begin
        conv_active <= 1'b1;
        timer       <= TMR_LOAD;
      end else if (conv_done) begin
        if (cm) timer       <= TMR_LOAD;
        else    conv_active <= 1'b0;
      end else if (conv_active) begin
        timer <= timer - TMR_W'(1);
      end

      if (blip) begin
        drdy <= 1'b0;
        blip <= 1'b0;
      end
      if (state == RDOUT && sclk_fall && !cs_s) drdy <= 1'b1;

      if (hold_new) begin
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
        // Unread data being overwritten: show a one-clock high pulse first.
        if (!drdy) begin
          drdy <= 1'b1;
          blip <= 1'b1;
        end else begin
          drdy <= 1'b0;
        end
      end
    end
  end

  // Shift registers and result storage.
  always_ff @(posedge clk) begin
    if (sclk_fall) shift_in <= rx_byte;
    if (load_result)    shift_out <= result;
    else if (load_reg)  shift_out <= {regs[load_addr], {(DATA_W-8){1'b0}}};
    else if (sclk_rise) shift_out <= {shift_out[DATA_W-2:0], 1'b0};
    if (commit)   result   <= commit_val;
    if (hold_new) pend_val <= sample_i;
  end

endmodule

// File: tb/tb_adc045_slave_model.sv
// Directed/randomized bench for adc045_slave_model acting as an SPI master.
module tb_adc045_slave_model;

  localparam int C = 400;

  logic        clk, rst_l, CS, SCLK, DIN, nRST, START;
  logic        DRDY, DOUT;
  logic [23:0] sample_i;
  logic [3:0]  mux_o;
  logic [31:0] cfg_o;

  int tests = 0;
  int fails = 0;
  logic [7:0] m_regs [4];
  logic drdy_first;

  adc045_slave_model #(.CONV_CYCLES(C), .DATA_W(24)) dut (
    .clk(clk), .rst_l(rst_l), .CS(CS), .SCLK(SCLK), .DIN(DIN),
    .nRST(nRST), .START(START), .DRDY(DRDY), .DOUT(DOUT),
    .sample_i(sample_i), .mux_o(mux_o), .cfg_o(cfg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before 500000 ns");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cfg_model();
    return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  // Mode 1 master: DIN changes with SCLK rising, both sides sample on falling.
  task automatic sclk_bits(input logic [31:0] mosi, input int n, output logic [31:0] got);
    got = '0;
    for (int i = n - 1; i >= 0; i--) begin
      SCLK = 1'b1;
      DIN  = mosi[i];
      repeat (5) @(negedge clk);
      SCLK = 1'b0;
      got  = {got[30:0], DOUT};
      repeat (5) @(negedge clk);
      if (i == n - 1) drdy_first = DRDY;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [31:0] g;
    sclk_bits({24'h0, b}, 8, g);
  endtask

  task automatic frame_begin();
    CS = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (6) @(negedge clk);
    CS = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_wreg(input logic [1:0] rr, input logic [1:0] nn, input logic [31:0] data);
    logic [1:0] a;
    a = rr;
    frame_begin();
    send_byte({4'h4, rr, nn});
    for (int k = 0; k <= int'(nn); k++) begin
      send_byte(data[31 - 8 * k -: 8]);
      m_regs[a] = data[31 - 8 * k -: 8];
      a = a + 2'd1;
    end
    frame_end();
  endtask

  task automatic check_rreg(input string tag, input logic [1:0] rr, input logic [1:0] nn);
    logic [31:0] got, exp;
    logic [1:0]  a;
    a   = rr;
    exp = '0;
    for (int k = 0; k <= int'(nn); k++) begin
      exp = {exp[23:0], m_regs[a]};
      a   = a + 2'd1;
    end
    frame_begin();
    send_byte({4'h2, rr, nn});
    sclk_bits(32'h0, (int'(nn) + 1) * 8, got);
    frame_end();
    check(tag, got, exp);
  endtask

  task automatic read_result(input string tag, input logic [23:0] exp);
    logic [31:0] got;
    frame_begin();
    sclk_bits(32'h0, 24, got);
    frame_end();
    check(tag, got, {8'h0, exp});
  endtask

  // Count clock edges until DRDY reaches lvl; a timeout returns budget.
  task automatic wait_drdy(input logic lvl, input int budget, output int n);
    n = 0;
    while (DRDY !== lvl && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int          n;
    logic [31:0] got, d;
    logic [23:0] sa, sb, s1, s2, s3;
    logic [7:0]  v, b0, b1;
    logic [1:0]  rr, nn;

    rst_l = 1'b0; CS = 1'b1; SCLK = 1'b0; DIN = 1'b0; nRST = 1'b1; START = 1'b0;
    sample_i = '0;
    drdy_first = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    repeat (5) @(negedge clk);
    rst_l = 1'b1;
    repeat (5) @(negedge clk);

    // reset state
    check("rst_drdy", 32'(DRDY), 32'd1);
    check("rst_dout", 32'(DOUT), 32'd0);
    check("rst_cfg", cfg_o, 32'h0);
    check("rst_mux", 32'(mux_o), 32'd0);

    // directed write / readback
    do_wreg(2'd0, 2'd3, 32'h8104AA55);
    check_rreg("rreg_0x23", 2'd0, 2'd3);
    check("wr_cfg", cfg_o, 32'h55AA0481);
    check("wr_mux", 32'(mux_o), 32'd8);
    check_rreg("rreg_wrap", 2'd3, 2'd3);

    // randomized write / readback against the register model
    for (int it = 0; it < 3; it++) begin
      rr = 2'($urandom); nn = 2'($urandom); d = $urandom;
      do_wreg(rr, nn, d);
      check("rand_cfg", cfg_o, cfg_model());
      rr = 2'($urandom); nn = 2'($urandom);
      check_rreg("rand_rreg", rr, nn);
    end

    // single-shot conversion from the START pin
    do_wreg(2'd1, 2'd0, 32'h0);
    sample_i = 24'hA5C3F0;
    START = 1'b1;
    wait_drdy(1'b0, C + 50, n);
    check("ss_latency", 32'(n), 32'(C + 3));
    @(negedge clk);
    START = 1'b0;
    read_result("ss_data", 24'hA5C3F0);
    check("ss_drdy_first_fall", 32'(drdy_first), 32'd1);
    repeat (C + 20) @(negedge clk);
    check("ss_no_refire", 32'(DRDY), 32'd1);

    // conversion completing in the middle of a read
    sa = 24'($urandom); sb = 24'($urandom);
    sample_i = sa;
    START = 1'b1;
    wait_drdy(1'b0, C + 50, n);
    check("mid_first_conv", 32'(n), 32'(C + 3));
    @(negedge clk);
    START = 1'b0;
    repeat (4) @(negedge clk);
    sample_i = sb;
    START = 1'b1;
    repeat (C - 80) @(negedge clk);
    START = 1'b0;
    read_result("mid_old_value", sa);
    check("mid_drdy_after", 32'(DRDY), 32'd0);
    read_result("mid_new_value", sb);

    // continuous mode with unread results
    v = 8'($urandom) | 8'h04;
    do_wreg(2'd1, 2'd0, {v, 24'h0});
    s1 = 24'($urandom); s2 = 24'($urandom); s3 = 24'($urandom);
    sample_i = s1;
    frame_begin(); send_byte(8'h08); frame_end();
    wait_drdy(1'b0, C + 50, n);
    check("cm_conv1", 32'(DRDY), 32'd0);
    sample_i = s2;
    wait_drdy(1'b1, C + 20, n);
    check("cm_period1", 32'(n), 32'(C));
    wait_drdy(1'b0, 10, n);
    check("cm_pulse1", 32'(n), 32'd1);
    sample_i = s3;
    wait_drdy(1'b1, C + 20, n);
    check("cm_period2", 32'(n), 32'(C - 1));
    wait_drdy(1'b0, 10, n);
    check("cm_pulse2", 32'(n), 32'd1);
    @(negedge clk);
    frame_begin();
    sclk_bits(32'h0, 24, got);
    send_byte(8'h02);
    frame_end();
    check("cm_read3", got, {8'h0, s3});
    repeat (C + 20) @(negedge clk);
    check("cm_powerdown", 32'(DRDY), 32'd1);

    // CS abort inside the second write data byte
    b0 = 8'($urandom); b1 = 8'($urandom);
    frame_begin();
    send_byte(8'h41);
    send_byte(b0);
    sclk_bits({28'h0, b1[7:4]}, 4, got);
    frame_end();
    m_regs[0] = b0;
    check("abort_cfg", cfg_o, cfg_model());
    v = 8'($urandom) & 8'hFB;
    do_wreg(2'd1, 2'd0, {v, 24'h0});
    check("abort_next_frame", cfg_o, cfg_model());

    // pin reset in the middle of a result read
    sa = 24'($urandom) | 24'h800000;
    sample_i = sa;
    START = 1'b1;
    wait_drdy(1'b0, C + 50, n);
    check("nrst_conv", 32'(n), 32'(C + 3));
    @(negedge clk);
    START = 1'b0;
    frame_begin();
    sclk_bits(32'h0, 8, got);
    check("nrst_partial", got, {24'h0, sa[23:16]});
    nRST = 1'b0;
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    check("nrst_cfg", cfg_o, 32'h0);
    check("nrst_drdy", 32'(DRDY), 32'd1);
    check("nrst_dout", 32'(DOUT), 32'd0);
    sclk_bits(32'h0, 8, got);
    check("nrst_idle_dout", got, 32'h0);
    frame_end();

    // RESET command: same register state, conversion dropped, FSM back in CMD
    d = $urandom; v = 8'($urandom);
    frame_begin();
    send_byte(8'h43);
    for (int k = 0; k < 4; k++) send_byte(d[31 - 8 * k -: 8]);
    send_byte(8'h08);
    send_byte(8'h06);
    send_byte(8'h40);
    send_byte(v);
    frame_end();
    m_regs[0] = v;
    check("rstcmd_cfg", cfg_o, cfg_model());
    check("rstcmd_drdy", 32'(DRDY), 32'd1);
    repeat (C + 20) @(negedge clk);
    check("rstcmd_conv_dropped", 32'(DRDY), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc045_slave_model.md
Name: adc045_slave_model

Overview:
- Synthesizable responder for the four-wire SPI converter link (CS/SCLK/DIN/DOUT plus DRDY/START/nRST) driven by the adc045 controller.
- Emulates the ADC side: decodes controller commands, holds the configuration registers, runs a conversion timer and shifts 24-bit results out.
- Used for FPGA loopback and for self-checking benches in place of the real converter. Sample values come from an internal port, with the mux selection exported.

Parameters:
- CONV_CYCLES, 50000: clk cycles per conversion (1 kHz at 50 MHz); must be ≥ 64.
- DATA_W, 24: conversion result width; fixed at 24.

Ports:
- clk, input, 1: system clock.
- rst_l, input, 1: synchronous active-low reset.
- CS, input, 1: chip select from the controller, active low.
- SCLK, input, 1: serial clock from the controller, idle low.
- DIN, input, 1: serial data from the controller.
- nRST, input, 1: converter reset pin, active low.
- START, input, 1: conversion start pin; the rising edge is significant.
- DRDY, output, 1: data ready, active low.
- DOUT, output, 1: serial data to the controller.
- sample_i, input, 24: sample value latched when a conversion ends.
- mux_o, output, 4: reg0[7:4], the channel selection.
- cfg_o, output, 32: {reg3, reg2, reg1, reg0}, exposed for checking.

Behaviour:
- Input synchronization
  - CS, SCLK, DIN, nRST and START each pass through a 2-flop synchronizer, followed by an edge-detect register.
  - Master requirement: SCLK high and low phases ≥ 4 clk; CS setup and hold to SCLK ≥ 4 clk.
- SPI mode 1
  - DIN is sampled on the detected SCLK falling edge.
  - DOUT changes on the detected SCLK rising edge.
  - DOUT latency is 3 clk from the pin edge.
- Reset
  - rst_l low, or synchronized nRST low: reg0..reg3 = 0; DRDY = 1; DOUT = 0; conversion idle; SPI FSM = IDLE; pending flag cleared.
- Registers
  - Four 8-bit registers.
  - reg1[2] = CM: 0 = single-shot, 1 = continuous.
  - All other bits are storage only.
- SPI FSM states: IDLE, CMD, RDOUT, WDATA, RDREG.
  - CS high (detected rising edge or level) from any state → IDLE immediately. The bit counter clears and any partial byte is discarded; bytes already completed remain written.
  - CS falling edge with DRDY = 0 → RDOUT. The shift register loads the result and DOUT is driven with the MSB in the same cycle.
  - CS falling edge with DRDY = 1 → CMD.
  - CMD: 8 bits, MSB first, then decode.
    - 0x06 RESET: same effect as reset, but the FSM returns to CMD.
    - 0x08 START: start conversion.
    - 0x02 POWERDOWN: stop the conversion timer.
    - 0x10 RDATA: load the result and go to RDOUT.
    - 0x4X WREG: rr = X[3:2], nn = X[1:0]; receive nn+1 bytes into rr, rr+1, … (the address wraps mod 4); go to WDATA.
    - 0x2X RREG: same fields; shift out nn+1 bytes; go to RDREG.
    - Any other byte is ignored and the FSM stays in CMD.
  - RDOUT: 24 bits MSB first, then CMD. DRDY goes to 1 on the first detected SCLK falling edge of the read.
  - WDATA / RDREG: return to CMD after the last byte. A register write takes effect at the 8th falling edge of its byte.
- Conversion
  - Triggered by the START pin rising edge or the START command. The timer loads CONV_CYCLES−1 and counts down to 0.
  - A retrigger mid-conversion restarts the count.
  - At 0: latch sample_i into result and set DRDY = 0.
    - CM = 1: reload the timer.
    - CM = 0: go idle.
  - If the result is still unread when a new result arrives (DRDY = 0), DRDY is 1 for exactly 1 clk and then returns to 0 with the new data.
  - If the FSM is in RDOUT when a conversion completes, the new value is held pending. It is committed (latch plus DRDY = 0) on the cycle the FSM leaves RDOUT.
  - If a conversion completes on the same cycle as a RESET or POWERDOWN decode, the reset or powerdown wins and the result is dropped.
- DOUT value
  - DOUT = 0 when not in RDOUT or RDREG, and also when CS is high.

Test Plan:
- Register write and readback: after reset, send WREG 0x43 with 0x81, 0x04, 0xAA, 0x55, then RREG 0x23 → DOUT returns 81 04 AA 55; cfg_o = 0x55AA0481; mux_o = 8.
- Single-shot conversion: START pulse with CM = 0 and sample_i = 0xA5C3F0 → DRDY falls CONV_CYCLES + 3 clk after the pin edge. A 24-SCLK read returns 0xA5C3F0 and DRDY rises at the first SCLK fall; no further DRDY fall follows.
- Continuous mode, unread data: CM = 1 with sample_i stepping 1, 2, 3 and no reads → one-clk DRDY high pulse at each conversion. A read after the third conversion returns 3.
- Conversion during a read: a conversion completes in the middle of a 24-bit read → the shifted value is the old one; the new value commits and DRDY = 0 after CS rises.
- CS abort: CS is raised after 4 bits of the second WREG data byte → reg0 is updated and reg1 is unchanged; the next frame decodes cleanly as a command.
- Pin reset: nRST low for 3 clk mid-RDOUT → registers = 0, DRDY = 1, DOUT = 0, FSM = IDLE; RESET command 0x06 gives identical register state.
